// File: rtl/cell_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cell_write_arbiter
// Brief    : Round-robin arbiter sharing one screen cell-writer port among
//            NUM_REQ requesters, with start-timeout and one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module cell_write_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int START_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_row,
    input  logic [4*NUM_REQ-1:0]   req_col,
    input  logic [4*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    input  logic                   working,
    output logic                   start_write,
    output logic [3:0]             cell_row,
    output logic [3:0]             cell_col,
    output logic [3:0]             cell_data,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   timeout_flag
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;

    localparam int            CW         = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CW-1:0] C_TMO_LAST = CW'(START_TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [2:0]         r_ptr;
    logic [CW-1:0]      r_cnt;

    logic [2:0]         w_next;
    logic               w_timeout;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_found;
    logic [2:0]         w_pick;
    logic [3:0]         w_row;
    logic [3:0]         w_col;
    logic [3:0]         w_data;
    logic [NUM_REQ-1:0] w_ack_oh;
    int                 w_dist;
    int                 w_best;

    assign w_cnt_inc = r_cnt + 1'b1;

    // Winner is the requester at the smallest wrapped distance from the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_row   = '0;
        w_col   = '0;
        w_data  = '0;
        w_dist  = 0;
        w_best  = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j]) begin
                w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NUM_REQ - int'(r_ptr));
                if (w_dist < w_best) begin
                    w_best  = w_dist;
                    w_found = 1'b1;
                    w_pick  = 3'(j);
                    w_row   = req_row[4*j +: 4];
                    w_col   = req_col[4*j +: 4];
                    w_data  = req_data[4*j +: 4];
                end
            end
        end
    end

    always_comb begin
        w_ack_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id == 3'(j)) begin
                w_ack_oh[j] = 1'b1;
            end
        end
    end

    // A rising working beats counter expiry in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:      if (w_found) w_next = S_START;
            S_START:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (working) begin
                    w_next = S_WAIT_DONE;
                end else if (w_cnt_inc == C_TMO_LAST) begin
                    w_next    = S_ACK;
                    w_timeout = 1'b1;
                end
            end
            S_WAIT_DONE: if (!working) w_next = S_ACK;
            S_ACK:       w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_cnt        <= '0;
            ack          <= '0;
            start_write  <= 1'b0;
            cell_row     <= '0;
            cell_col     <= '0;
            cell_data    <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            r_state     <= w_next;
            busy        <= (w_next != S_IDLE);
            start_write <= (w_next == S_START);
            ack         <= (w_next == S_ACK) ? w_ack_oh : '0;
            if (w_timeout) begin
                timeout_flag <= 1'b1;
            end
            if (r_state == S_IDLE && w_found) begin
                cell_row  <= w_row;
                cell_col  <= w_col;
                cell_data <= w_data;
                grant_id  <= w_pick;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY && !working) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == S_ACK) begin
                r_ptr <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : (grant_id + 3'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cell_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_write_arbiter
// Brief    : Self-checking bench for cell_write_arbiter with a behavioural
//            round-robin / timing reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_write_arbiter;

    localparam int N   = 3;
    localparam int TMO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [4*N-1:0]   req_row = '0;
    logic [4*N-1:0]   req_col = '0;
    logic [4*N-1:0]   req_data = '0;
    logic             working = 1'b0;
    logic [N-1:0]     ack;
    logic             start_write;
    logic [3:0]       cell_row;
    logic [3:0]       cell_col;
    logic [3:0]       cell_data;
    logic [2:0]       grant_id;
    logic             busy;
    logic             timeout_flag;

    cell_write_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_row      (req_row),
        .req_col      (req_col),
        .req_data     (req_data),
        .ack          (ack),
        .working      (working),
        .start_write  (start_write),
        .cell_row     (cell_row),
        .cell_col     (cell_col),
        .cell_data    (cell_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = 0;

    logic [3:0] f_row [N];
    logic [3:0] f_col [N];
    logic [3:0] f_data[N];

    // Observations from the most recent transaction.
    int         t_sw, t_ack;
    bit         obs_hung;
    logic       obs_sw2;
    logic [3:0] obs_row, obs_col, obs_data;
    logic [2:0] obs_grant;
    logic [N-1:0] obs_ack, obs_ack_next;
    logic       obs_tflag, obs_tflag_start;

    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_fields(input int i, input logic [3:0] r, input logic [3:0] c, input logic [3:0] d);
        f_row[i] = r; f_col[i] = c; f_data[i] = d;
        req_row[4*i +: 4] = r; req_col[4*i +: 4] = c; req_data[4*i +: 4] = d;
    endtask

    // Writer model: working high from d to d+h-1 cycles after start_write (d<0: never).
    task automatic run_txn(input int d, input int h);
        int  k;
        bit  got;
        obs_hung = 1'b0; obs_ack = '0; obs_ack_next = '1; obs_sw2 = 1'b1;
        k = 0;
        while (start_write !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (start_write !== 1'b1) begin
            obs_hung = 1'b1;
            return;
        end
        t_sw = cyc; obs_row = cell_row; obs_col = cell_col; obs_data = cell_data;
        obs_grant = grant_id; obs_tflag_start = timeout_flag;
        got = 1'b0;
        for (int c = 0; c < 80; c++) begin
            working = (d >= 0 && c >= d && c < d + h);
            if (c == 1) obs_sw2 = start_write;
            if (got) begin
                obs_ack_next = ack;
                return;
            end
            if (ack !== '0) begin
                got = 1'b1; obs_ack = ack; t_ack = cyc; obs_tflag = timeout_flag;
                req = req & ~ack;
            end
            @(negedge clk);
        end
        obs_hung = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_total++; if (ack !== '0) $display("FAIL reset_ack got %b exp 0", ack); else n_pass++;
        n_total++; if (start_write !== 1'b0) $display("FAIL reset_start got %b exp 0", start_write); else n_pass++;
        n_total++; if ({cell_row, cell_col, cell_data} !== 12'h000) $display("FAIL reset_cell got %h exp 000", {cell_row, cell_col, cell_data}); else n_pass++;
        n_total++; if (grant_id !== 3'd0) $display("FAIL reset_grant got %0d exp 0", grant_id); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (timeout_flag !== 1'b0) $display("FAIL reset_tflag got %b exp 0", timeout_flag); else n_pass++;
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single;
        int t_req, exp;
        @(negedge clk);
        set_fields(0, 4'd5, 4'd7, 4'd9);
        req = 3'b001;
        exp = model_pick(req, m_ptr);
        t_req = cyc;
        run_txn(1, 10);
        n_total++; if (obs_hung) $display("FAIL single_hung got 1 exp 0"); else n_pass++;
        n_total++; if (t_sw !== t_req + 1) $display("FAIL single_latency got %0d exp %0d", t_sw - t_req, 1); else n_pass++;
        n_total++; if ({obs_row, obs_col, obs_data} !== 12'h579) $display("FAIL single_fields got %h exp 579", {obs_row, obs_col, obs_data}); else n_pass++;
        n_total++; if (obs_grant !== 3'(exp)) $display("FAIL single_grant got %0d exp %0d", obs_grant, exp); else n_pass++;
        n_total++; if (obs_sw2 !== 1'b0) $display("FAIL single_start_width got %b exp 0", obs_sw2); else n_pass++;
        n_total++; if (obs_ack !== onehot(exp)) $display("FAIL single_ack got %b exp %b", obs_ack, onehot(exp)); else n_pass++;
        n_total++; if (t_ack !== t_sw + 12) $display("FAIL single_ack_time got %0d exp %0d", t_ack - t_sw, 12); else n_pass++;
        n_total++; if (obs_ack_next !== '0) $display("FAIL single_ack_width got %b exp 0", obs_ack_next); else n_pass++;
        m_ptr = (exp + 1) % N;
    endtask

    task automatic test_round_robin;
        logic [N-1:0] steps[4];
        int exp;
        steps = '{3'b111, 3'b001, 3'b100, 3'b101};
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) set_fields(i, 4'($urandom), 4'($urandom), 4'($urandom));
        for (int s = 0; s < 4; s++) begin
            req = steps[s];
            while (req !== '0) begin
                exp = model_pick(req, m_ptr);
                run_txn(1 + $urandom_range(0, 3), 1 + $urandom_range(0, 4));
                n_total++; if (obs_grant !== 3'(exp)) $display("FAIL rr_grant step %0d got %0d exp %0d", s, obs_grant, exp); else n_pass++;
                n_total++; if (obs_ack !== onehot(exp)) $display("FAIL rr_ack step %0d got %b exp %b", s, obs_ack, onehot(exp)); else n_pass++;
                n_total++; if ({obs_row, obs_col, obs_data} !== {f_row[exp], f_col[exp], f_data[exp]}) $display("FAIL rr_fields step %0d got %h exp %h", s, {obs_row, obs_col, obs_data}, {f_row[exp], f_col[exp], f_data[exp]}); else n_pass++;
                m_ptr = (exp + 1) % N;
                if (obs_hung) req = '0;
            end
        end
    endtask

    task automatic test_timeout;
        int exp;
        set_fields(1, 4'd2, 4'd3, 4'd4);
        req = 3'b010;
        exp = model_pick(req, m_ptr);
        run_txn(-1, 0);
        n_total++; if (obs_ack !== 3'b010) $display("FAIL tmo_ack got %b exp 010", obs_ack); else n_pass++;
        n_total++; if (t_ack !== t_sw + TMO) $display("FAIL tmo_time got %0d exp %0d", t_ack - t_sw, TMO); else n_pass++;
        n_total++; if (obs_tflag_start !== 1'b0) $display("FAIL tmo_flag_before got %b exp 0", obs_tflag_start); else n_pass++;
        n_total++; if (obs_tflag !== 1'b1) $display("FAIL tmo_flag got %b exp 1", obs_tflag); else n_pass++;
        m_ptr = (exp + 1) % N;
        req = 3'b001;
        exp = model_pick(req, m_ptr);
        run_txn(2, 3);
        n_total++; if (obs_ack !== onehot(exp)) $display("FAIL tmo_next_ack got %b exp %b", obs_ack, onehot(exp)); else n_pass++;
        n_total++; if (obs_tflag !== 1'b1) $display("FAIL tmo_sticky got %b exp 1", obs_tflag); else n_pass++;
        m_ptr = (exp + 1) % N;
    endtask

    task automatic test_late_fields;
        int k, bad;
        bit got;
        logic [N-1:0] a;
        set_fields(2, 4'd1, 4'd1, 4'd3);
        req = 3'b100;
        k = 0;
        while (start_write !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        req_data[8 +: 4] = 4'd8;
        bad = 0; got = 1'b0; a = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            working = (c >= 1 && c < 5);
            if (cell_data !== 4'd3) bad++;
            if (ack !== '0) begin got = 1'b1; a = ack; req = req & ~ack; end
            @(negedge clk);
        end
        n_total++; if (bad !== 0) $display("FAIL late_data cycles_changed %0d exp 0 (now %0d)", bad, cell_data); else n_pass++;
        n_total++; if (a !== 3'b100) $display("FAIL late_ack got %b exp 100", a); else n_pass++;
        set_fields(2, 4'd1, 4'd1, 4'd3);
        m_ptr = 0;
    endtask

    task automatic test_reset_mid;
        int k, seen;
        set_fields(0, 4'hA, 4'hB, 4'hC);
        req = 3'b001;
        k = 0;
        while (start_write !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        for (int c = 0; c < 3; c++) begin
            working = (c >= 1);
            @(negedge clk);
        end
        n_total++; if (busy !== 1'b1) $display("FAIL rmid_busy_before got %b exp 1", busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = '0; working = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
        n_total++; if ({ack, start_write} !== '0) $display("FAIL rmid_ack_start got %b exp 0", {ack, start_write}); else n_pass++;
        n_total++; if ({cell_row, cell_col, cell_data, grant_id} !== '0) $display("FAIL rmid_fields got %h exp 0", {cell_row, cell_col, cell_data, grant_id}); else n_pass++;
        n_total++; if (timeout_flag !== 1'b0) $display("FAIL rmid_tflag got %b exp 0", timeout_flag); else n_pass++;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (ack !== '0) seen++;
            @(negedge clk);
        end
        n_total++; if (seen !== 0) $display("FAIL rmid_no_ack got %0d acks exp 0", seen); else n_pass++;
        m_ptr = 0;
    endtask

    task automatic test_boundary;
        int exp;
        set_fields(0, 4'd6, 4'd6, 4'd6);
        req = 3'b001;
        exp = model_pick(req, m_ptr);
        run_txn(TMO - 1, 3);
        n_total++; if (obs_tflag !== 1'b0) $display("FAIL bnd_tflag got %b exp 0", obs_tflag); else n_pass++;
        n_total++; if (t_ack !== t_sw + TMO - 1 + 3 + 1) $display("FAIL bnd_ack_time got %0d exp %0d", t_ack - t_sw, TMO + 3); else n_pass++;
        n_total++; if (obs_ack !== onehot(exp)) $display("FAIL bnd_ack got %b exp %b", obs_ack, onehot(exp)); else n_pass++;
        m_ptr = (exp + 1) % N;
    endtask

    task automatic test_back_to_back;
        int e1, e2, a1, g1;
        req = 3'b011;
        e1 = model_pick(req, m_ptr);
        run_txn(1, 2);
        a1 = t_ack; g1 = obs_grant;
        m_ptr = (e1 + 1) % N;
        e2 = model_pick(req, m_ptr);
        run_txn(2, 2);
        m_ptr = (e2 + 1) % N;
        n_total++; if (g1 !== e1) $display("FAIL b2b_first got %0d exp %0d", g1, e1); else n_pass++;
        n_total++; if (obs_grant !== 3'(e2)) $display("FAIL b2b_second got %0d exp %0d", obs_grant, e2); else n_pass++;
        n_total++; if (t_sw !== a1 + 2) $display("FAIL b2b_spacing got %0d exp 2", t_sw - a1); else n_pass++;
    endtask

    task automatic test_random;
        int exp, d, h, prev_ack;
        bit first;
        first = 1'b1; prev_ack = 0;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    set_fields(i, 4'($urandom), 4'($urandom), 4'($urandom));
                    req[i] = 1'b1;
                end
            end
            if (req === '0) begin
                exp = $urandom_range(0, N - 1);
                set_fields(exp, 4'($urandom), 4'($urandom), 4'($urandom));
                req[exp] = 1'b1;
            end
            exp = model_pick(req, m_ptr);
            d = $urandom_range(1, 6);
            h = $urandom_range(1, 5);
            run_txn(d, h);
            n_total++; if (obs_grant !== 3'(exp)) $display("FAIL rnd_grant it %0d got %0d exp %0d", it, obs_grant, exp); else n_pass++;
            n_total++; if ({obs_row, obs_col, obs_data} !== {f_row[exp], f_col[exp], f_data[exp]}) $display("FAIL rnd_fields it %0d got %h exp %h", it, {obs_row, obs_col, obs_data}, {f_row[exp], f_col[exp], f_data[exp]}); else n_pass++;
            n_total++; if (obs_ack !== onehot(exp)) $display("FAIL rnd_ack it %0d got %b exp %b", it, obs_ack, onehot(exp)); else n_pass++;
            n_total++; if (t_ack !== t_sw + d + h + 1) $display("FAIL rnd_ack_time it %0d got %0d exp %0d", it, t_ack - t_sw, d + h + 1); else n_pass++;
            if (!first) begin
                n_total++; if (t_sw !== prev_ack + 2) $display("FAIL rnd_spacing it %0d got %0d exp 2", it, t_sw - prev_ack); else n_pass++;
            end
            first = 1'b0;
            prev_ack = t_ack;
            m_ptr = (exp + 1) % N;
            if (obs_hung) req = '0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_late_fields();
        test_reset_mid();
        test_boundary();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d exp finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cell_write_arbiter.md
Name: cell_write_arbiter

Overview:
- Shares the single screen cell-writer port (start_write / cell_row / cell_col / cell_data, with working as the writer's busy signal) among NUM_REQ requesters: board sync, cursor overlay and solver update.
- Grants round-robin and latches the winner's cell fields.
- Pulses start_write, then tracks working through its rise and fall.
- Returns a one-cycle ack to the winner.
- Sits between the game/solver logic and the screen write engine.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
START_TIMEOUT, 16, max cycles in WAIT_BUSY for working to rise before the write is abandoned

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  request per requester; held high with fields stable until ack
req_row  in  4*NUM_REQ  packed row per requester; bits [4i+3:4i] belong to requester i
req_col  in  4*NUM_REQ  packed column per requester, same packing
req_data  in  4*NUM_REQ  packed cell value per requester, same packing
ack  out  NUM_REQ  one-hot one-cycle pulse to the serviced requester
working  in  1  writer busy; high while the writer draws a cell
start_write  out  1  one-cycle write strobe to the writer
cell_row  out  4  latched row of the current grant
cell_col  out  4  latched column of the current grant
cell_data  out  4  latched value of the current grant
grant_id  out  3  index of the current/last granted requester
busy  out  1  high in every state except IDLE
timeout_flag  out  1  sticky; set on any START_TIMEOUT expiry; cleared only by rst

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, rr pointer 0, timeout counter 0, and ack, start_write, cell_row, cell_col, cell_data, grant_id, busy and timeout_flag all 0.
- rst has priority over everything. Reset mid-transaction returns to IDLE with no ack. start_write drops the next edge.
- FSM states are IDLE, START, WAIT_BUSY, WAIT_DONE and ACK.
- IDLE:
  - If any req bit is set, pick the first set index at or after the rr pointer, scanning upward with wrap at NUM_REQ-1 to 0.
  - Latch that index's row, col and data into cell_*. Set grant_id. Go to START.
- START:
  - start_write=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - working is not sampled in START.
- WAIT_BUSY:
  - working=1 goes to WAIT_DONE.
  - Otherwise, increment the counter. When the counter reaches START_TIMEOUT-1, set timeout_flag and go to ACK.
  - Sampling working=1 takes precedence over expiry in the same cycle.
- WAIT_DONE: stay while working=1. working=0 goes to ACK. There is no timeout in this state.
- ACK:
  - ack[grant_id]=1 for this cycle only. rr pointer = (grant_id+1) mod NUM_REQ. Go to IDLE.
  - A timed-out write is still acked.
- Grant latency: req seen in IDLE at edge k gives start_write high in cycle k+1.
- Minimum ack-to-next-start_write spacing is 2 cycles: ACK, then IDLE, then START.
- A requester dropping req before grant is simply skipped.
- Changing req or fields after grant has no effect, because the fields are already latched.
- req must drop the cycle after ack, otherwise the requester is re-arbitrated as a new request.
- cell_* and grant_id hold their last values in IDLE. They change only on a new grant.
- busy = (state != IDLE).

Test Plan:
- Single request:
  - Stimulus: rst released, req=001, req_row[3:0]=5, req_col[3:0]=7, req_data[3:0]=9. Writer model raises working 1 cycle after start_write, holds it 10 cycles, then drops it.
  - Required response: start_write pulses once, 1 cycle after req is sampled, with cell_row/col/data=5/7/9. ack=001 for one cycle, 1 cycle after working falls.
- Round-robin:
  - Stimulus: req=111 held, each requester dropping its req after its ack.
  - Required response: grant order 0, 1, 2. After only requester 0 re-requests, it is granted next. Then req=101 with pointer at 0 grants 0, then 2.
- Timeout:
  - Stimulus: req=010, working held 0.
  - Required response: START_TIMEOUT=16 cycles after start_write, ack=010 pulses and timeout_flag=1. A later normal write leaves timeout_flag at 1.
- Late fields:
  - Stimulus: req_data changes from 3 to 8 on the cycle after grant.
  - Required response: cell_data stays 3 throughout the transaction.
- Reset mid-transaction:
  - Stimulus: assert rst for 1 cycle while in WAIT_DONE with working=1.
  - Required response: next cycle busy=0, no ack, all outputs 0.
- Boundary and back-to-back:
  - Stimulus: working rises on the same cycle the counter expires; separately, two requesters are queued back-to-back.
  - Required response: on simultaneous rise and expiry, the FSM goes to WAIT_DONE with timeout_flag=0. For the queued pair, the second start_write follows the first ack by exactly 2 cycles.
